digit_serial_multiplier: RTL and testbench
==========================================

Name: digit_serial_multiplier

Overview:
Parametrised multi-cycle multiplier; successor to the fixed 8x8 nibble-serial multiplier. Multiplies two WIDTH-bit operands one DIGIT-bit slice of operand B per cycle and accumulates shifted partial products. Adds what the fixed block lacks: start/busy/done handshake, per-operation signed/unsigned mode, and operand/digit widths set by parameter. Sits between operand registers and the result consumer in the arithmetic datapath.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2 and a multiple of DIGIT.
DIGIT, 4, bits of in_b consumed per compute cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of compute cycles.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
in_a  input  WIDTH  multiplicand; sampled with start.
in_b  input  WIDTH  multiplier; sampled with start.
busy  output  1  high from the accepting edge until the result edge.
done  output  1  one-cycle pulse; out_data is valid from this cycle on.
out_data  output  2*WIDTH  product; holds until the next result edge.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0; done=0; out_data=0; accumulator, counter, captured operands and sign = 0. Reset mid-operation aborts it; no done is produced.
- States: IDLE, COMPUTE, FINISH.
- IDLE, start=1 at edge E0:
  - capture a_mag = |in_a| and b_mag = |in_b| when signed_mode=1, else raw values;
  - capture neg = signed_mode & (in_a[MSB] ^ in_b[MSB]);
  - acc=0, cnt=0, busy=1, go to COMPUTE.
- IDLE, start=0: remain in IDLE.
- |-2^(WIDTH-1)| = 2^(WIDTH-1) is held as an unsigned WIDTH-bit value; no overflow.
- COMPUTE, each edge:
  - acc += (a_mag * b_mag[cnt*DIGIT +: DIGIT]) << (cnt*DIGIT), in 2*WIDTH bits, no truncation loss;
  - cnt++;
  - when cnt == NDIG-1 on this edge, go to FINISH.
- FINISH, one edge:
  - out_data = neg ? (~acc + 1) : acc;
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after edge E0+NDIG+1. Example: WIDTH=8, DIGIT=4 gives 3 edges.
- Throughput: start may be held or re-asserted while done is high; it is accepted at the next edge. One operation per NDIG+2 cycles.
- start while busy (COMPUTE or FINISH) is ignored, not queued. Input changes after E0 have no effect.
- Product range: unsigned max (2^WIDTH-1)^2 and signed min*min = 2^(2*WIDTH-2) both fit in 2*WIDTH bits; no saturation.
- Zero operand: full NDIG cycles still run; result 0, neg is irrelevant.
- done and busy are never high in the same cycle.

Test Plan:
- Reset: assert rst mid-COMPUTE -> busy=0, done=0, out_data=0 immediately (asynchronous); no done pulse afterwards.
- Unsigned, W=8/D=4: start with 0x0A*0x0B -> done 3 edges later, out_data=0x006E. Then 0x7C*0x12 -> 0x08B8. Then 0xAB*0xCD -> 0x88EF.
- Mode: 0xFF*0x94 with signed_mode=0 -> 0x936C. Same operands with signed_mode=1 -> 0x006C. 0x80*0x80 signed -> 0x4000. 0x80*0x01 signed -> 0xFF80.
- Handshake: pulse start during busy with other operands -> ignored, original result returned. Hold start high continuously -> back-to-back results, one done every 4 cycles; busy never overlaps done.
- Parametrisation W=16/D=4 (NDIG=4, done after 5 edges): 0xFFFF*0xFFFF unsigned -> 0xFFFE0001; signed -> 0x00000001. W=8/D=8: 0xFF*0xFF -> 0xFE01 after 2 edges. W=8/D=1: same 0xFF*0xFF -> 0xFE01 after 9 edges.
- Hold: after done, change inputs with start=0 for 10 cycles -> out_data stable, busy=0, no further done.

Source files
------------

// File: rtl/digit_serial_multiplier_if.sv
// Operand/result handshake bundle for the digit-serial multiplier.
// The master issues start with operands; the slave returns busy/done/product.
interface digit_serial_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out_data;

    modport master (
        output start, signed_mode, in_a, in_b,
        input  busy, done, out_data
    );

    modport slave (
        input  start, signed_mode, in_a, in_b,
        output busy, done, out_data
    );
endinterface

// File: rtl/digit_serial_multiplier.sv
// Multi-cycle WIDTH x WIDTH multiplier consuming DIGIT bits of the multiplier
// per cycle. Signed operation multiplies magnitudes and negates the result.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; last product held on out_data
// S_COMPUTE | one partial product per edge, NDIG edges in total
// S_FINISH  | apply sign, publish product, pulse done
module digit_serial_multiplier #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic clk,
    input  logic rst,
    digit_serial_multiplier_if.slave bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]     b_sh_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   out_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     a_abs_d;
    logic [WIDTH-1:0]     b_abs_d;
    logic                 neg_d;
    logic [2*WIDTH-1:0]   pp_d;

    // Operand magnitudes at capture, and the current shifted partial product.
    // The multiplicand is kept pre-shifted and the multiplier pre-shifted down,
    // so pp_d equals a_mag * b_mag[cnt*DIGIT +: DIGIT] << (cnt*DIGIT) without
    // variable indexing. |min| = 2^(WIDTH-1) fits the unsigned WIDTH-bit field.
    always_comb begin
        a_abs_d = bus.in_a;
        b_abs_d = bus.in_b;
        if (bus.signed_mode && bus.in_a[WIDTH-1]) a_abs_d = ~bus.in_a + WIDTH'(1);
        if (bus.signed_mode && bus.in_b[WIDTH-1]) b_abs_d = ~bus.in_b + WIDTH'(1);
        neg_d = bus.signed_mode & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
        pp_d  = a_sh_q * {{(2*WIDTH-DIGIT){1'b0}}, b_sh_q[DIGIT-1:0]};
    end

    // Sequencer and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= {{WIDTH{1'b0}}, a_abs_d};
                        b_sh_q  <= b_abs_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    acc_q  <= acc_q + pp_d;
                    a_sh_q <= a_sh_q << DIGIT;
                    b_sh_q <= b_sh_q >> DIGIT;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_q <= S_FINISH;
                end
                S_FINISH: begin
                    out_q   <= neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out_data = out_q;
endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Directed bench for digit_serial_multiplier across four parametrisations.
module tb_digit_serial_multiplier;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    digit_serial_multiplier_if #(.WIDTH(8))  if84 ();
    digit_serial_multiplier_if #(.WIDTH(16)) if164 ();
    digit_serial_multiplier_if #(.WIDTH(8))  if88 ();
    digit_serial_multiplier_if #(.WIDTH(8))  if81 ();

    digit_serial_multiplier #(.WIDTH(8),  .DIGIT(4)) u84  (.clk(clk), .rst(rst), .bus(if84));
    digit_serial_multiplier #(.WIDTH(16), .DIGIT(4)) u164 (.clk(clk), .rst(rst), .bus(if164));
    digit_serial_multiplier #(.WIDTH(8),  .DIGIT(8)) u88  (.clk(clk), .rst(rst), .bus(if88));
    digit_serial_multiplier #(.WIDTH(8),  .DIGIT(1)) u81  (.clk(clk), .rst(rst), .bus(if81));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic sm,
                         input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0: begin if84.start = st;  if84.signed_mode = sm;  if84.in_a = a[7:0]; if84.in_b = b[7:0]; end
            1: begin if164.start = st; if164.signed_mode = sm; if164.in_a = a;     if164.in_b = b;     end
            2: begin if88.start = st;  if88.signed_mode = sm;  if88.in_a = a[7:0]; if88.in_b = b[7:0]; end
            default: begin if81.start = st; if81.signed_mode = sm; if81.in_a = a[7:0]; if81.in_b = b[7:0]; end
        endcase
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: return if84.done;
            1: return if164.done;
            2: return if88.done;
            default: return if81.done;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return if84.busy;
            1: return if164.busy;
            2: return if88.busy;
            default: return if81.busy;
        endcase
    endfunction

    function automatic logic [63:0] out_of(input int sel);
        case (sel)
            0: return 64'(if84.out_data);
            1: return 64'(if164.out_data);
            2: return 64'(if88.out_data);
            default: return 64'(if81.out_data);
        endcase
    endfunction

    // One full operation: start pulse, operands scrambled after acceptance,
    // then latency (edges after the accepting edge), product and busy checked.
    task automatic run_op(input int sel, input logic sm, input logic [15:0] a,
                          input logic [15:0] b, input logic [63:0] exp,
                          input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, sm, a, b);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~sm, ~a, b ^ 16'h5A5A);
        chk({tag, "_busy"}, 64'(busy_of(sel)), 64'd1);
        n = 0;
        while (!done_of(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_out"}, out_of(sel), exp);
        chk({tag, "_busy_at_done"}, 64'(busy_of(sel)), 64'd0);
    endtask

    initial begin
        int n;
        int cnt;
        int first;
        int second;
        int overlap;
        logic [63:0] held;
        logic bad_out;
        logic bad_ctl;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 1'b0, 16'h0, 16'h0);
        #12;
        chk("rst_busy", 64'(if84.busy), 64'd0);
        chk("rst_done", 64'(if84.done), 64'd0);
        chk("rst_out",  64'(if84.out_data), 64'd0);
        chk("rst_out16", 64'(if164.out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 1'b0, 16'h0A, 16'h0B, 64'h006E, 3, "u_0a0b");
        run_op(0, 1'b0, 16'h7C, 16'h12, 64'h08B8, 3, "u_7c12");
        run_op(0, 1'b0, 16'hAB, 16'hCD, 64'h88EF, 3, "u_abcd");
        run_op(0, 1'b0, 16'hFF, 16'h94, 64'h936C, 3, "u_ff94");
        run_op(0, 1'b1, 16'hFF, 16'h94, 64'h006C, 3, "s_ff94");
        run_op(0, 1'b1, 16'h80, 16'h80, 64'h4000, 3, "s_8080");
        run_op(0, 1'b1, 16'h80, 16'h01, 64'hFF80, 3, "s_8001");
        run_op(0, 1'b1, 16'h00, 16'h85, 64'h0000, 3, "s_zero");

        // start pulsed mid-operation with other operands must be ignored
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0A, 16'h0B);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0A, 16'h0B);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h33, 16'h44);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h00, 16'h00);
        n = 1;
        while (!if84.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_lat", 64'(n), 64'd3);
        chk("ign_out", 64'(if84.out_data), 64'h006E);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (if84.done) cnt++;
        end
        chk("ign_no_extra_done", 64'(cnt), 64'd0);

        // start held high: done on edges 4, 8, 12 after raising it
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0A, 16'h0B);
        cnt = 0; first = 0; second = 0; overlap = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (if84.busy && if84.done) overlap++;
            if (if84.done) begin
                cnt++;
                if (cnt == 1) first = e;
                if (cnt == 2) second = e;
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0A, 16'h0B);
        chk("b2b_count",   64'(cnt), 64'd3);
        chk("b2b_first",   64'(first), 64'd4);
        chk("b2b_spacing", 64'(second - first), 64'd4);
        chk("b2b_overlap", 64'(overlap), 64'd0);
        chk("b2b_out",     64'(if84.out_data), 64'h006E);

        run_op(1, 1'b0, 16'hFFFF, 16'hFFFF, 64'hFFFE0001, 5, "w16_u");
        run_op(1, 1'b1, 16'hFFFF, 16'hFFFF, 64'h00000001, 5, "w16_s");
        run_op(1, 1'b1, 16'h8000, 16'h0003, 64'hFFFE8000, 5, "w16_neg");
        run_op(2, 1'b0, 16'hFF,   16'hFF,   64'hFE01,     2, "d8_u");
        run_op(3, 1'b0, 16'hFF,   16'hFF,   64'hFE01,     9, "d1_u");
        run_op(3, 1'b1, 16'h80,   16'h7F,   64'hC080,     9, "d1_s");

        // output holds while inputs wander with start low
        @(negedge clk);
        held = 64'(if84.out_data);
        bad_out = 1'b0;
        bad_ctl = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'(i), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
            @(posedge clk); #1;
            if (64'(if84.out_data) !== held) bad_out = 1'b1;
            if (if84.busy || if84.done) bad_ctl = 1'b1;
        end
        chk("hold_out_stable", 64'(bad_out), 64'd0);
        chk("hold_idle",       64'(bad_ctl), 64'd0);
        chk("hold_value",      held, 64'h006E);

        // asynchronous reset in the middle of COMPUTE
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'hAB, 16'hCD);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'hAB, 16'hCD);
        @(posedge clk); #2;
        chk("pre_rst_busy", 64'(if84.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(if84.busy), 64'd0);
        chk("mid_rst_done", 64'(if84.done), 64'd0);
        chk("mid_rst_out",  64'(if84.out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if84.done || if84.busy) cnt++;
        end
        chk("post_rst_quiet", 64'(cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
